// File: rtl/spi_segment_ctrl.sv
// -----------------------------------------------------------------------------
// spi_segment_ctrl
//
// SPI-slave (mode 0) register controller for a 7-segment output path.
// A 16-bit frame {W, 5'bx, addr[1:0], data[7:0]} is shifted in MSB first.
// Write frames update reg[addr] on the 16th SCK rise; read frames return
// reg[addr] on MISO during the data byte. The segment output applies enable,
// invert and a MAX_COUNT-timed blink to the SEG register.
//
// Register map:
//   0 SEG     pattern {dp,g,f,e,d,c,b,a}         reset 8'h00
//   1 CTRL    bit0 EN, bit1 BLINK, bit2 INV       reset 8'h01
//   2 SCRATCH general purpose                     reset 8'h00
//   3 STATUS  {4'h0, frame_cnt} read-only
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   spi_sck     SPI clock (asynchronous to clk)
//   spi_cs_n    SPI chip select, active-low
//   spi_mosi    SPI data in, MSB first
//   spi_miso    SPI data out, MSB first (registered)
//   seg_out     segment drive, active-high (registered)
//   frame_done  one-clk pulse per completed 16-bit frame
// -----------------------------------------------------------------------------
module spi_segment_ctrl #(
   parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sck,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic [7:0] seg_out,
   output logic       frame_done
);

   typedef enum logic [1:0] {
      ST_IDLE,   // CS seen high, waiting for CS low
      ST_SHIFT,  // frame in progress
      ST_DONE    // frame complete or ignored, waiting for CS high
   } state_t;

   // ---------------------------------------------------------------------------
   // Input synchronizers and SCK edge detection
   // ---------------------------------------------------------------------------
   logic [1:0] sck_sync;
   logic [1:0] cs_sync;
   logic [1:0] mosi_sync;
   logic       sck_d;
   logic       sck_s;
   logic       cs_s;
   logic       mosi_s;
   logic       sck_rise;
   logic       sck_fall;

   // NOTE: sequential state is always assigned with non-blocking (<=) so every
   // flop samples the pre-edge value of its neighbours, as real hardware does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync  <= 2'b00;
         // CS reads as asserted out of reset: a frame already in progress
         // keeps the FSM parked in ST_DONE until CS is genuinely seen high.
         cs_sync   <= 2'b00;
         mosi_sync <= 2'b00;
         sck_d     <= 1'b0;
      end else begin
         sck_sync  <= {sck_sync[0], spi_sck};
         cs_sync   <= {cs_sync[0], spi_cs_n};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sck_d     <= sck_sync[1];
      end
   end

   assign sck_s    = sck_sync[1];
   assign cs_s     = cs_sync[1];
   assign mosi_s   = mosi_sync[1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;

   // ---------------------------------------------------------------------------
   // Frame decode
   // ---------------------------------------------------------------------------
   state_t      state;
   logic [4:0]  bit_cnt;
   logic [14:0] shift_in;
   logic [7:0]  tx_reg;
   logic [15:0] frame_word;   // frame including the bit arriving this cycle
   logic        in_frame_rise;
   logic        load_tx;
   logic        commit_en;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;

   logic [7:0]  seg_reg;
   logic [2:0]  ctrl_reg;
   logic [7:0]  scratch_reg;
   logic [3:0]  frame_cnt;
   logic [7:0]  rd_data;

   assign frame_word    = {shift_in, mosi_s};
   assign in_frame_rise = (state == ST_SHIFT) && !cs_s && sck_rise;
   assign load_tx       = in_frame_rise && (bit_cnt == 5'd7);
   assign commit_en     = in_frame_rise && (bit_cnt == 5'd15);
   assign wr_en         = commit_en && frame_word[15];
   assign wr_addr       = frame_word[9:8];
   assign wr_data       = frame_word[7:0];

   // On the 8th rise the command byte is frame_word[7:0]; addr is its low bits.
   // NOTE: every output of an always_comb gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rd_data = 8'h00;
      case (frame_word[1:0])
         2'd0:    rd_data = seg_reg;
         2'd1:    rd_data = {5'b0, ctrl_reg};
         2'd2:    rd_data = scratch_reg;
         default: rd_data = {4'h0, frame_cnt};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_DONE;
         bit_cnt    <= 5'd0;
         shift_in   <= 15'd0;
         tx_reg     <= 8'h00;
         spi_miso   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               spi_miso <= 1'b0;
               if (!cs_s) begin
                  state    <= ST_SHIFT;
                  bit_cnt  <= 5'd0;
                  shift_in <= 15'd0;
                  tx_reg   <= 8'h00;
               end
            end
            ST_SHIFT: begin
               if (cs_s) begin
                  // Early CS release: drop the partial frame silently.
                  state    <= ST_IDLE;
                  spi_miso <= 1'b0;
               end else if (sck_rise) begin
                  shift_in <= frame_word[14:0];
                  bit_cnt  <= bit_cnt + 5'd1;
                  if (load_tx) begin
                     tx_reg <= rd_data;
                  end
                  if (commit_en) begin
                     frame_done <= 1'b1;
                     state      <= ST_DONE;
                  end
               end else if (sck_fall && (bit_cnt >= 5'd8)) begin
                  spi_miso <= tx_reg[7];
                  tx_reg   <= {tx_reg[6:0], 1'b0};
               end
            end
            ST_DONE: begin
               // Extra SCK edges are ignored here; only CS high re-arms.
               if (cs_s) begin
                  state    <= ST_IDLE;
                  spi_miso <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_reg     <= 8'h00;
         ctrl_reg    <= 3'b001;
         scratch_reg <= 8'h00;
         frame_cnt   <= 4'd0;
      end else begin
         if (commit_en) begin
            frame_cnt <= frame_cnt + 4'd1;
         end
         if (wr_en) begin
            case (wr_addr)
               2'd0:    seg_reg     <= wr_data;
               2'd1:    ctrl_reg    <= wr_data[2:0];
               2'd2:    scratch_reg <= wr_data;
               default: ;  // STATUS is read-only
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Blink timer
   // ---------------------------------------------------------------------------
   logic [23:0] blink_cnt;
   logic        phase;
   logic        blink_next;

   // Looking at the incoming CTRL value lets a commit that clears BLINK win
   // over a timer wrap in the same cycle. Counting starts once BLINK is
   // registered so the first phase is a full MAX_COUNT cycles on the output.
   assign blink_next = (wr_en && (wr_addr == 2'd1)) ? wr_data[1] : ctrl_reg[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= 24'd0;
         phase     <= 1'b0;
      end else if (!blink_next) begin
         blink_cnt <= 24'd0;
         phase     <= 1'b0;
      end else if (ctrl_reg[1]) begin
         if (blink_cnt == MAX_COUNT - 24'd1) begin
            blink_cnt <= 24'd0;
            phase     <= ~phase;
         end else begin
            blink_cnt <= blink_cnt + 24'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Segment output
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_out <= 8'h00;
      end else if (ctrl_reg[0]) begin
         seg_out <= ((ctrl_reg[1] && phase) ? 8'h00 : seg_reg) ^ {8{ctrl_reg[2]}};
      end else begin
         seg_out <= 8'h00;
      end
   end

endmodule
